// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: run/pause/clear FSM driving a BCD MM:SS counter from a 1 Hz enable.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  input  logic       lap_pulse,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt_mt, cnt_mo, cnt_st, cnt_so;
  logic [3:0] inc_mt, inc_mo, inc_st, inc_so;
  logic [3:0] nxt_mt, nxt_mo, nxt_st, nxt_so;
  logic       at_max;
  logic       count_en;
  logic       hold_nxt;

  // Start/pause toggle; clear is handled with priority in the register block
  always_comb begin
    state_nxt = state;
    if (pause_pulse) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSED;
        PAUSED:  state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign count_en = (state == RUN) && tick_1hz;

  // BCD cascade: seconds roll 59 -> 00, minutes roll MAX_MIN -> 00
  always_comb begin
    inc_mt = cnt_mt;
    inc_mo = cnt_mo;
    inc_st = cnt_st;
    inc_so = cnt_so;
    at_max = 1'b0;
    if (cnt_so != 4'd9) begin
      inc_so = cnt_so + 4'd1;
    end else begin
      inc_so = 4'd0;
      if (cnt_st != 4'd5) begin
        inc_st = cnt_st + 4'd1;
      end else begin
        inc_st = 4'd0;
        if (cnt_mt == MAX_MT && cnt_mo == MAX_MO) begin
          inc_mt = 4'd0;
          inc_mo = 4'd0;
          at_max = 1'b1;
        end else if (cnt_mo != 4'd9) begin
          inc_mo = cnt_mo + 4'd1;
        end else begin
          inc_mo = 4'd0;
          inc_mt = cnt_mt + 4'd1;
        end
      end
    end
  end

  assign nxt_mt = count_en ? inc_mt : cnt_mt;
  assign nxt_mo = count_en ? inc_mo : cnt_mo;
  assign nxt_st = count_en ? inc_st : cnt_st;
  assign nxt_so = count_en ? inc_so : cnt_so;

`ifdef STOPWATCH_LAP_EN
  logic lap_hold;
  assign hold_nxt = lap_hold ^ (lap_pulse && (state != IDLE));
`else
  logic unused_lap;
  assign unused_lap = lap_pulse;
  assign hold_nxt   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || clear_pulse) begin
      state    <= IDLE;
      cnt_mt   <= 4'd0;
      cnt_mo   <= 4'd0;
      cnt_st   <= 4'd0;
      cnt_so   <= 4'd0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      running  <= 1'b0;
      wrap     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_hold <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt_mt  <= nxt_mt;
      cnt_mo  <= nxt_mo;
      cnt_st  <= nxt_st;
      cnt_so  <= nxt_so;
      running <= (state_nxt == RUN);
      wrap    <= count_en && at_max;
`ifdef STOPWATCH_LAP_EN
      lap_hold <= hold_nxt;
`endif
      // Display tracks the live count unless a lap hold is active
      if (!hold_nxt) begin
        min_tens <= nxt_mt;
        min_ones <= nxt_mo;
        sec_tens <= nxt_st;
        sec_ones <= nxt_so;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: vector table plus multi-cycle corner sequences.
// Lap checks compile in when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, pause_pulse, clear_pulse, lap_pulse;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, wrap;

  int checks   = 0;
  int failures = 0;

  stopwatch_ctrl #(.MAX_MIN(59)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .pause_pulse (pause_pulse),
    .clear_pulse (clear_pulse),
    .lap_pulse   (lap_pulse),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        pause;
    logic        clear;
    logic        lap;
    logic        tick;
    logic [15:0] exp_digits;
    logic        exp_running;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic r, input logic p, input logic c, input logic l, input logic t);
    rst_n = r; pause_pulse = p; clear_pulse = c; lap_pulse = l; tick_1hz = t;
    @(posedge clk);
    #1;
    rst_n = 1'b1; pause_pulse = 1'b0; clear_pulse = 1'b0; lap_pulse = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [15:0] exp_d, input logic exp_r, input logic exp_w);
    logic [15:0] act_d;
    act_d = {min_tens, min_ones, sec_tens, sec_ones};
    checks++;
    if (act_d !== exp_d || running !== exp_r || wrap !== exp_w) begin
      failures++;
      $display("FAIL %s: got digits=%h running=%b wrap=%b, expected digits=%h running=%b wrap=%b",
               name, act_d, running, wrap, exp_d, exp_r, exp_w);
    end
  endtask

  task automatic restart();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  int wrap_count;

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; pause_pulse = 1'b0; clear_pulse = 1'b0; lap_pulse = 1'b0;

    //              rst  pau  clr  lap  tick  digits    run   wrap
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}); // reset
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}); // tick in IDLE
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0}); // start
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0}); // pause+tick in RUN
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0}); // frozen
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0}); // resume, tick dropped
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}); // clear+tick
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}); // start+tick in IDLE
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}); // clear beats pause
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}); // reset beats all

    foreach (vecs[i]) begin
      cyc(vecs[i].rst_n, vecs[i].pause, vecs[i].clear, vecs[i].lap, vecs[i].tick);
      check($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_running, vecs[i].exp_wrap);
    end

    // 75 ticks from a fresh start
    restart();
    ticks(75);
    check("count_75", 16'h0115, 1'b1, 1'b0);

    // Run up to and through the MAX_MIN boundary
    ticks(3539 - 75);
    check("at_5859", 16'h5859, 1'b1, 1'b0);
    ticks(1);
    check("at_5900", 16'h5900, 1'b1, 1'b0);
    ticks(58);
    check("at_5958", 16'h5958, 1'b1, 1'b0);
    ticks(1);
    check("at_5959", 16'h5959, 1'b1, 1'b0);
    ticks(1);
    check("wrap_0000", 16'h0000, 1'b1, 1'b1);
    wrap_count = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, (i == 1) ? 1'b1 : 1'b0);
      if (wrap) wrap_count++;
    end
    checks++;
    if (wrap_count != 0) begin
      failures++;
      $display("FAIL wrap_width: got %0d extra wrap cycles, expected 0", wrap_count);
    end
    check("after_wrap", 16'h0001, 1'b1, 1'b0);

    // Pause with coincident tick, then resume
    restart();
    ticks(10);
    check("pr_0010", 16'h0010, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("pr_pause", 16'h0011, 1'b0, 1'b0);
    ticks(5);
    check("pr_frozen", 16'h0011, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pr_resume", 16'h0011, 1'b1, 1'b0);
    ticks(1);
    check("pr_count", 16'h0012, 1'b1, 1'b0);

    // Clear from PAUSED at 03:27
    restart();
    ticks(207);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cl_paused", 16'h0327, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("cl_clear", 16'h0000, 1'b0, 1'b0);
    ticks(1);
    check("cl_ignored", 16'h0000, 1'b0, 1'b0);

    // Reset mid-run at 12:34
    restart();
    ticks(754);
    check("rs_1234", 16'h1234, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rs_reset", 16'h0000, 1'b0, 1'b0);
    ticks(3);
    check("rs_idle", 16'h0000, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("lap_idle", 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(20);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_hold", 16'h0020, 1'b1, 1'b0);
    ticks(10);
    check("lap_frozen", 16'h0020, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lap_release", 16'h0030, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(5);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_clear", 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(2);
    check("lap_cleared_live", 16'h0002, 1'b1, 1'b0);
`else
    restart();
    ticks(20);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("nolap_live", 16'h0021, 1'b1, 1'b0);
    ticks(9);
    check("nolap_count", 16'h0030, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
